acs_metric_buffer: RTL and testbench

Receive side of the ACS stage metric output. Captures the 16 even/odd accumulated-metric pairs produced per trellis stage into a ping-pong buffer and tracks the minimum metric and its state index. On request, it replays the 32 metrics, normalized by subtracting that minimum, as a serial `accMetricIn`-style stream for the next ACS stage. It sits between consecutive ACS stages in the STC demodulator trellis.

---
 rtl/acs_metric_buffer_pkg.sv | 15 +
 rtl/acs_metric_buffer_ram.sv | 23 ++
 rtl/acs_metric_buffer.sv | 236 +++++++++++++++++++++++
 tb/tb_acs_metric_buffer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acs_metric_buffer_pkg.sv
// Shared constants and types for the ACS metric buffer between trellis stages.
package acsPkg;

    localparam int unsigned METRIC_W    = 18;
    localparam int unsigned NUM_PAIRS   = 16;
    localparam int unsigned NUM_STATES  = 2 * NUM_PAIRS;
    localparam int unsigned STATE_IDX_W = $clog2(NUM_STATES);
    localparam int unsigned PAIR_IDX_W  = STATE_IDX_W - 1;

    typedef enum logic {
        StIdle = 1'b0,
        StRead = 1'b1
    } rdState_e;

endpackage

// File: rtl/acs_metric_buffer_ram.sv
// Simple dual-port distributed RAM: one synchronous write port, one registered read port.
module metricBankRam #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wrAddr] <= wrData;
        end
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/acs_metric_buffer.sv
// Ping-pong buffer for one trellis stage of ACS metrics: captures even/odd pairs,
// tracks the minimum, and replays the 32 metrics normalized by that minimum.
module acs_metric_buffer
    import acsPkg::*;
(
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   clkEn,
    input  logic                   startFrame,
    input  logic                   metricInEn,
    input  logic [METRIC_W-1:0]    metricEvenIn,
    input  logic [METRIC_W-1:0]    metricOddIn,
    input  logic                   readStart,
    output logic                   accMetricOutEn,
    output logic [METRIC_W-1:0]    accMetricOut,
    output logic [METRIC_W-1:0]    minMetric,
    output logic [STATE_IDX_W-1:0] minIndex,
    output logic                   minValid,
    output logic [1:0]             bankReady,
    output logic                   overflow
);

    localparam logic [PAIR_IDX_W-1:0]  LAST_PAIR  = PAIR_IDX_W'(NUM_PAIRS - 1);
    localparam logic [STATE_IDX_W-1:0] LAST_STATE = STATE_IDX_W'(NUM_STATES - 1);

    logic                   frameRst;
    logic                   pairAccept;
    logic                   pairDrop;
    logic                   bankDone;
    logic                   rdDone;

    logic                   wrBank;
    logic [PAIR_IDX_W-1:0]  wrCnt;
    logic [METRIC_W-1:0]    runMin;
    logic [STATE_IDX_W-1:0] runIdx;
    logic [METRIC_W-1:0]    bankMin [2];
    logic [1:0]             bankReadyD;

    logic [METRIC_W-1:0]    evenMin;
    logic [STATE_IDX_W-1:0] evenIdx;
    logic [METRIC_W-1:0]    pairMin;
    logic [STATE_IDX_W-1:0] pairIdx;

    rdState_e               state;
    rdState_e               stateD;
    logic [STATE_IDX_W-1:0] rdCnt;
    logic [STATE_IDX_W-1:0] rdCntD;
    logic                   rdBank;
    logic                   rdBankD;
    logic                   outEnD;
    logic [STATE_IDX_W-1:0] rdAddr;

    logic [METRIC_W-1:0]    evenRdData [2];
    logic [METRIC_W-1:0]    oddRdData [2];
    logic [METRIC_W-1:0]    ramData;
    logic [METRIC_W-1:0]    normMetric;

    assign frameRst   = clkEn & startFrame;
    assign pairAccept = metricInEn & ~bankReady[wrBank] & ~frameRst;
    assign pairDrop   = metricInEn & bankReady[wrBank] & ~frameRst;
    assign bankDone   = pairAccept & (wrCnt == LAST_PAIR);

    // Even is compared before odd and only a strictly smaller value wins, so ties keep
    // the lower state index. The first pair of a bank ignores the stale running minimum.
    always_comb begin
        if ((wrCnt == '0) || (metricEvenIn < runMin)) begin
            evenMin = metricEvenIn;
            evenIdx = {wrCnt, 1'b0};
        end else begin
            evenMin = runMin;
            evenIdx = runIdx;
        end
        if (metricOddIn < evenMin) begin
            pairMin = metricOddIn;
            pairIdx = {wrCnt, 1'b1};
        end else begin
            pairMin = evenMin;
            pairIdx = evenIdx;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wrBank     <= 1'b0;
            wrCnt      <= '0;
            runMin     <= '0;
            runIdx     <= '0;
            bankMin[0] <= '0;
            bankMin[1] <= '0;
            minMetric  <= '0;
            minIndex   <= '0;
            minValid   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            minValid <= bankDone;
            if (frameRst) begin
                wrBank   <= 1'b0;
                wrCnt    <= '0;
                overflow <= 1'b0;
            end else begin
                if (pairDrop) begin
                    overflow <= 1'b1;
                end
                if (pairAccept) begin
                    runMin <= pairMin;
                    runIdx <= pairIdx;
                    if (bankDone) begin
                        bankMin[wrBank] <= pairMin;
                        minMetric       <= pairMin;
                        minIndex        <= pairIdx;
                        wrBank          <= ~wrBank;
                        wrCnt           <= '0;
                    end else begin
                        wrCnt <= wrCnt + PAIR_IDX_W'(1);
                    end
                end
            end
        end
    end

    // A bank being filled is never ready and a bank being read always is,
    // so set and clear never target the same bit.
    always_comb begin
        bankReadyD = bankReady;
        if (bankDone) begin
            bankReadyD[wrBank] = 1'b1;
        end
        if (rdDone) begin
            bankReadyD[rdBank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bankReady <= 2'b00;
        end else if (frameRst) begin
            bankReady <= 2'b00;
        end else begin
            bankReady <= bankReadyD;
        end
    end

    // In StRead, rdCnt is the index now held in the RAM read register; the next
    // address is issued one ahead, and address 0 is presented while idle so the
    // first metric is already in flight in the readStart cycle.
    always_comb begin
        stateD  = state;
        rdCntD  = rdCnt;
        rdBankD = rdBank;
        rdDone  = 1'b0;
        outEnD  = 1'b0;
        if (frameRst) begin
            stateD  = StIdle;
            rdCntD  = '0;
            rdBankD = 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (readStart && bankReady[rdBank]) begin
                        stateD = StRead;
                        rdCntD = '0;
                    end
                end
                StRead: begin
                    outEnD = 1'b1;
                    if (rdCnt == LAST_STATE) begin
                        rdDone  = 1'b1;
                        stateD  = StIdle;
                        rdCntD  = '0;
                        rdBankD = ~rdBank;
                    end else begin
                        rdCntD = rdCnt + STATE_IDX_W'(1);
                    end
                end
            endcase
        end
    end

    assign rdAddr = (state == StRead) ? (rdCnt + STATE_IDX_W'(1)) : '0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state  <= StIdle;
            rdCnt  <= '0;
            rdBank <= 1'b0;
        end else begin
            state  <= stateD;
            rdCnt  <= rdCntD;
            rdBank <= rdBankD;
        end
    end

    // Two RAMs per bank so an even/odd pair is written in a single cycle.
    for (genvar b = 0; b < 2; b++) begin : gBank
        logic bankWe;
        assign bankWe = pairAccept & (wrBank == 1'(b));

        metricBankRam #(
            .DATA_W(METRIC_W),
            .ADDR_W(STATE_IDX_W)
        ) uEvenRam (
            .clk   (clk),
            .we    (bankWe),
            .wrAddr({wrCnt, 1'b0}),
            .wrData(metricEvenIn),
            .rdAddr(rdAddr),
            .rdData(evenRdData[b])
        );

        metricBankRam #(
            .DATA_W(METRIC_W),
            .ADDR_W(STATE_IDX_W)
        ) uOddRam (
            .clk   (clk),
            .we    (bankWe),
            .wrAddr({wrCnt, 1'b1}),
            .wrData(metricOddIn),
            .rdAddr(rdAddr),
            .rdData(oddRdData[b])
        );
    end

    assign ramData    = rdCnt[0] ? oddRdData[rdBank] : evenRdData[rdBank];
    assign normMetric = ramData - bankMin[rdBank];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            accMetricOutEn <= 1'b0;
            accMetricOut   <= '0;
        end else begin
            accMetricOutEn <= outEnD;
            accMetricOut   <= outEnD ? normMetric : '0;
        end
    end

endmodule

// File: tb/tb_acs_metric_buffer.sv
// Directed, table-driven bench for acs_metric_buffer: fill, replay, ping-pong,
// overflow, abort and asynchronous reset.
module tb_acs_metric_buffer;
    import acsPkg::*;

    logic                   clk = 1'b0;
    logic                   resetN;
    logic                   clkEn;
    logic                   startFrame;
    logic                   metricInEn;
    logic [METRIC_W-1:0]    metricEvenIn;
    logic [METRIC_W-1:0]    metricOddIn;
    logic                   readStart;
    logic                   accMetricOutEn;
    logic [METRIC_W-1:0]    accMetricOut;
    logic [METRIC_W-1:0]    minMetric;
    logic [STATE_IDX_W-1:0] minIndex;
    logic                   minValid;
    logic [1:0]             bankReady;
    logic                   overflow;

    always #5 clk = ~clk;

    acs_metric_buffer dut (
        .clk           (clk),
        .resetN        (resetN),
        .clkEn         (clkEn),
        .startFrame    (startFrame),
        .metricInEn    (metricInEn),
        .metricEvenIn  (metricEvenIn),
        .metricOddIn   (metricOddIn),
        .readStart     (readStart),
        .accMetricOutEn(accMetricOutEn),
        .accMetricOut  (accMetricOut),
        .minMetric     (minMetric),
        .minIndex      (minIndex),
        .minValid      (minValid),
        .bankReady     (bankReady),
        .overflow      (overflow)
    );

    // Table 0: basic ramp (min 100 @0); 1: tie at 7/19 (min 40 @7); 2: min 3 @5.
    typedef struct {
        logic [METRIC_W-1:0] evenIn;
        logic [METRIC_W-1:0] oddIn;
        logic [METRIC_W-1:0] expEven;
        logic [METRIC_W-1:0] expOdd;
    } pairVec_t;

    pairVec_t tbl [3][16];
    int nCompared   = 0;
    int nMismatched = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [METRIC_W-1:0] expAt(input int t, input int i);
        return (i % 2 == 0) ? tbl[t][i / 2].expEven : tbl[t][i / 2].expOdd;
    endfunction

    task automatic checkZero(input string name);
        check(name, 64'({accMetricOutEn, accMetricOut, minMetric, minIndex, minValid,
                         bankReady, overflow}), 64'd0);
    endtask

    task automatic fillBank(input int t, input int unsigned expMin, input int unsigned expIdx,
                            input logic [1:0] expReady, input string name);
        for (int k = 0; k < 16; k++) begin
            metricInEn   = 1'b1;
            metricEvenIn = tbl[t][k].evenIn;
            metricOddIn  = tbl[t][k].oddIn;
            tick();
            if (k == 14) check({name, "_minValid_early"}, 64'(minValid), 64'd0);
        end
        metricInEn = 1'b0;
        check({name, "_minValid"}, 64'(minValid), 64'd1);
        check({name, "_minMetric"}, 64'(minMetric), 64'(expMin));
        check({name, "_minIndex"}, 64'(minIndex), 64'(expIdx));
        check({name, "_bankReady"}, 64'(bankReady), 64'(expReady));
        tick();
        check({name, "_minValid_pulse"}, 64'(minValid), 64'd0);
    endtask

    task automatic replay(input int t, input logic [1:0] expReadyAfter, input string name);
        readStart = 1'b1;
        tick();
        readStart = 1'b0;
        check({name, "_lat1"}, 64'(accMetricOutEn), 64'd0);
        for (int i = 0; i < 32; i++) begin
            tick();
            check($sformatf("%s_out[%0d]", name, i), 64'({accMetricOutEn, accMetricOut}),
                  64'({1'b1, expAt(t, i)}));
        end
        check({name, "_readyClr"}, 64'(bankReady), 64'(expReadyAfter));
        tick();
        check({name, "_enEnd"}, 64'(accMetricOutEn), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            tbl[0][k].evenIn  = METRIC_W'(100 + 2 * k);
            tbl[0][k].oddIn   = METRIC_W'(101 + 2 * k);
            tbl[0][k].expEven = METRIC_W'(2 * k);
            tbl[0][k].expOdd  = METRIC_W'(2 * k + 1);
            tbl[1][k].evenIn  = METRIC_W'(500);
            tbl[1][k].oddIn   = (k == 3 || k == 9) ? METRIC_W'(40) : METRIC_W'(500);
            tbl[1][k].expEven = METRIC_W'(460);
            tbl[1][k].expOdd  = (k == 3 || k == 9) ? METRIC_W'(0) : METRIC_W'(460);
            tbl[2][k].evenIn  = METRIC_W'(50 + k);
            tbl[2][k].oddIn   = (k == 2) ? METRIC_W'(3) : METRIC_W'(20 + 3 * k);
            tbl[2][k].expEven = METRIC_W'(47 + k);
            tbl[2][k].expOdd  = (k == 2) ? METRIC_W'(0) : METRIC_W'(17 + 3 * k);
        end

        resetN       = 1'b0;
        clkEn        = 1'b0;
        startFrame   = 1'b0;
        metricInEn   = 1'b0;
        metricEvenIn = '0;
        metricOddIn  = '0;
        readStart    = 1'b0;
        #12;
        checkZero("reset");
        tick();
        tick();
        resetN = 1'b1;
        tick();

        fillBank(0, 100, 0, 2'b01, "basic");
        replay(0, 2'b00, "basic");
        fillBank(1, 40, 7, 2'b10, "tie");
        replay(1, 2'b00, "tie");

        // Ping-pong: replay bank 0 while bank 1 fills.
        fillBank(0, 100, 0, 2'b01, "pp0");
        readStart    = 1'b1;
        metricInEn   = 1'b1;
        metricEvenIn = tbl[2][0].evenIn;
        metricOddIn  = tbl[2][0].oddIn;
        for (int c = 1; c <= 33; c++) begin
            tick();
            readStart = 1'b0;
            if (c < 16) begin
                metricEvenIn = tbl[2][c].evenIn;
                metricOddIn  = tbl[2][c].oddIn;
            end else begin
                metricInEn = 1'b0;
            end
            if (c == 1) check("pp_lat1", 64'(accMetricOutEn), 64'd0);
            else check($sformatf("pp_out[%0d]", c - 2), 64'({accMetricOutEn, accMetricOut}),
                       64'({1'b1, expAt(0, c - 2)}));
            if (c == 16) begin
                check("pp_minValid", 64'(minValid), 64'd1);
                check("pp_minMetric", 64'(minMetric), 64'd3);
                check("pp_minIndex", 64'(minIndex), 64'd5);
                check("pp_bothReady", 64'(bankReady), 64'(2'b11));
            end
            if (c == 33) check("pp_ready0Clr", 64'(bankReady), 64'(2'b10));
        end
        replay(2, 2'b00, "pp1");

        // Overflow: both banks full, one more pair is dropped.
        fillBank(0, 100, 0, 2'b01, "ov0");
        fillBank(2, 3, 5, 2'b11, "ov1");
        metricInEn   = 1'b1;
        metricEvenIn = METRIC_W'(7);
        metricOddIn  = METRIC_W'(7);
        tick();
        metricInEn = 1'b0;
        check("ov_flag", 64'(overflow), 64'd1);
        check("ov_ready", 64'(bankReady), 64'(2'b11));
        check("ov_noMinValid", 64'(minValid), 64'd0);
        tick();
        check("ov_sticky", 64'(overflow), 64'd1);
        replay(0, 2'b10, "ov_rd0");
        fillBank(1, 40, 7, 2'b11, "ov_refill");

        // Abort replay of bank 1 at cycle 10; startFrame without clkEn at cycle 5 is ignored.
        readStart = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            readStart = 1'b0;
            if (c == 1) check("ab_lat1", 64'(accMetricOutEn), 64'd0);
            else check($sformatf("ab_out[%0d]", c - 2), 64'({accMetricOutEn, accMetricOut}),
                       64'({1'b1, expAt(2, c - 2)}));
            startFrame = (c == 5 || c == 10);
            clkEn      = (c == 10);
        end
        tick();
        startFrame = 1'b0;
        clkEn      = 1'b0;
        check("ab_enLow", 64'(accMetricOutEn), 64'd0);
        check("ab_ready", 64'(bankReady), 64'd0);
        check("ab_overflow", 64'(overflow), 64'd0);
        readStart = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            readStart = 1'b0;
            check($sformatf("ab_ignored[%0d]", c), 64'(accMetricOutEn), 64'd0);
        end

        // startFrame beats a simultaneous pair; the refill must still take exactly 16 pairs.
        startFrame   = 1'b1;
        clkEn        = 1'b1;
        metricInEn   = 1'b1;
        metricEvenIn = METRIC_W'(1);
        metricOddIn  = METRIC_W'(1);
        tick();
        startFrame = 1'b0;
        clkEn      = 1'b0;
        metricInEn = 1'b0;
        check("sf_pairDropped", 64'({minValid, bankReady}), 64'd0);
        fillBank(1, 40, 7, 2'b01, "sf_fill");

        // Asynchronous reset in the middle of filling bank 1.
        for (int k = 0; k < 5; k++) begin
            metricInEn   = 1'b1;
            metricEvenIn = tbl[0][k].evenIn;
            metricOddIn  = tbl[0][k].oddIn;
            tick();
        end
        #3 resetN = 1'b0;
        #1 checkZero("rst_fill");
        metricInEn = 1'b0;
        #1 resetN = 1'b1;
        tick();
        fillBank(0, 100, 0, 2'b01, "post_rst");
        replay(0, 2'b00, "post_rst");

        // Asynchronous reset in the middle of a replay.
        fillBank(1, 40, 7, 2'b10, "pre_rdrst");
        readStart = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            readStart = 1'b0;
        end
        check("rdrst_active", 64'(accMetricOutEn), 64'd1);
        #3 resetN = 1'b0;
        #1 checkZero("rst_read");
        #1 resetN = 1'b1;
        tick();
        fillBank(2, 3, 5, 2'b01, "final");
        replay(2, 2'b00, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
